// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_stage_pkg : shared widths, encodings and constants for fetch    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package if_id_stage_pkg;

  localparam int          c_XLEN     = 32;
  localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [c_XLEN-1:0] word_align(input logic [c_XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_stage_if : req/ack instruction-memory port                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface if_id_stage_if;
  import if_id_stage_pkg::*;

  logic              imem_req;
  logic [c_XLEN-1:0] imem_addr;
  logic              imem_ack;
  logic [c_XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/if_id_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register with hold and flush-to-bubble     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_id_reg
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = c_NOP_INSN
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load,
  input  wire logic              bubble,
  input  wire logic [c_XLEN-1:0] d_pc,
  input  wire logic [c_XLEN-1:0] d_ir,
  output logic      [c_XLEN-1:0] id_pc,
  output logic      [c_XLEN-1:0] id_pc4,
  output logic      [c_XLEN-1:0] id_ir,
  output logic                   id_valid
);

  logic [c_XLEN-1:0] r_pc;
  logic [c_XLEN-1:0] r_pc4;
  logic [c_XLEN-1:0] r_ir;
  logic              r_valid;

  // A bubble keeps the last pc/pc4 so ID still sees a sensible PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_pc4   <= '0;
      r_ir    <= NOP_INSN;
      r_valid <= 1'b0;
    end else if (bubble) begin
      r_ir    <= NOP_INSN;
      r_valid <= 1'b0;
    end else if (load) begin
      r_pc    <= d_pc;
      r_pc4   <= d_pc + 32'd4;
      r_ir    <= d_ir;
      r_valid <= 1'b1;
    end
  end

  assign id_pc    = r_pc;
  assign id_pc4   = r_pc4;
  assign id_ir    = r_ir;
  assign id_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_stage : PC, fetch FSM with skid buffer, and IF/ID register      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC,
  parameter logic [31:0] NOP_INSN = c_NOP_INSN
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              stall,
  input  wire logic              flush,
  input  wire logic [c_XLEN-1:0] redirect_pc,
  if_id_stage_if.master          imem,
  output logic      [c_XLEN-1:0] id_pc,
  output logic      [c_XLEN-1:0] id_pc4,
  output logic      [c_XLEN-1:0] id_ir,
  output logic                   id_valid
);

  state_e            r_state;
  logic [c_XLEN-1:0] r_pc;
  logic [c_XLEN-1:0] r_pend_pc;
  logic [c_XLEN-1:0] r_skid_pc;
  logic [c_XLEN-1:0] r_skid_ir;

  logic [c_XLEN-1:0] w_redirect;
  logic              w_load;
  logic              w_bubble;
  logic [c_XLEN-1:0] w_d_pc;
  logic [c_XLEN-1:0] w_d_ir;

  assign w_redirect = word_align(redirect_pc);

  // Memory shares rst, so the request drops immediately without waiting for the edge.
  assign imem.imem_req  = !rst && (r_state == ST_FETCH || r_state == ST_DRAIN);
  assign imem.imem_addr = r_pc;

  always_comb begin
    w_load   = 1'b0;
    w_bubble = 1'b0;
    w_d_pc   = r_pc;
    w_d_ir   = imem.imem_rdata;
    case (r_state)
      ST_FETCH: begin
        if (flush)                           w_bubble = 1'b1;
        else if (imem.imem_ack && !stall)    w_load   = 1'b1;
        else if (!imem.imem_ack && !stall)   w_bubble = 1'b1;
      end
      ST_HOLD: begin
        if (flush) begin
          w_bubble = 1'b1;
        end else if (!stall) begin
          w_load = 1'b1;
          w_d_pc = r_skid_pc;
          w_d_ir = r_skid_ir;
        end
      end
      default: w_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= word_align(RESET_PC);
      r_pend_pc <= '0;
      r_skid_pc <= '0;
      r_skid_ir <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (flush) begin
            if (imem.imem_ack) begin
              r_pc <= w_redirect;
            end else begin
              r_pend_pc <= w_redirect;
              r_state   <= ST_DRAIN;
            end
          end else if (imem.imem_ack) begin
            if (!stall) begin
              r_pc <= r_pc + 32'd4;
            end else begin
              r_skid_pc <= r_pc;
              r_skid_ir <= imem.imem_rdata;
              r_state   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (flush) begin
            r_pc    <= w_redirect;
            r_state <= ST_FETCH;
          end else if (!stall) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // The newest redirect wins, even if it lands on the draining ack.
          if (imem.imem_ack) begin
            r_pc    <= flush ? w_redirect : r_pend_pc;
            r_state <= ST_FETCH;
          end else if (flush) begin
            r_pend_pc <= w_redirect;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSN (NOP_INSN)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .bubble   (w_bubble),
    .d_pc     (w_d_pc),
    .d_ir     (w_d_ir),
    .id_pc    (id_pc),
    .id_pc4   (id_pc4),
    .id_ir    (id_ir),
    .id_valid (id_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_id_stage : directed stimulus with a queue-based ID scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_if_id_stage;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] id_pc, id_pc4, id_ir;
  logic        id_valid;

  if_id_stage_if imem ();

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_ir       (id_ir),
    .id_valid    (id_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [95:0] exp_q[$];
  logic        done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // A new instruction is presented when id_valid is set after an edge that saw no stall.
  always @(posedge clk) begin
    logic s_stall, s_rst;
    logic [95:0] e;
    s_stall = stall;
    s_rst   = rst;
    #1;
    if (!done && !s_rst && !s_stall && id_valid) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL id_unexpected: got pc=%h ir=%h, expected no valid instruction", id_pc, id_ir);
      end else begin
        e = exp_q.pop_front();
        if ({id_pc, id_pc4, id_ir} === e) n_pass++;
        else $display("FAIL id_out: got pc=%h pc4=%h ir=%h expected pc=%h pc4=%h ir=%h",
                      id_pc, id_pc4, id_ir, e[95:64], e[63:32], e[31:0]);
      end
    end
  end

  task automatic step(input logic a, input logic [31:0] d, input logic s,
                      input logic f, input logic [31:0] r);
    @(negedge clk);
    imem.imem_ack   = a;
    imem.imem_rdata = d;
    stall           = s;
    flush           = f;
    redirect_pc     = r;
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ir);
    exp_q.push_back({pc, pc4, ir});
  endtask

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ir", id_ir, c_NOP);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);

    // 0-wait fetches from 0 and 4
    @(negedge clk); rst = 1'b0;
    step(1, 32'h0050_0093, 0, 0, 0);
    chk("req_first", {31'd0, imem.imem_req}, 32'd1);
    chk("addr_0", imem.imem_addr, 32'h0);
    push(32'h0, 32'h4, 32'h0050_0093);
    step(1, 32'hA000_0004, 0, 0, 0);
    chk("addr_4", imem.imem_addr, 32'h4);
    chk("ir_first", id_ir, 32'h0050_0093);
    push(32'h4, 32'h8, 32'hA000_0004);

    // Stall 3 cycles while the word for 8 arrives
    step(1, 32'hA000_0008, 1, 0, 0);
    chk("addr_8", imem.imem_addr, 32'h8);
    step(0, 32'hDEAD_0000, 1, 0, 0);
    chk("hold_req", {31'd0, imem.imem_req}, 32'd0);
    step(0, 32'hDEAD_0001, 1, 0, 0);
    chk("hold_ir_stable", id_ir, 32'hA000_0004);
    step(0, 32'hDEAD_0002, 0, 0, 0);
    chk("hold_req2", {31'd0, imem.imem_req}, 32'd0);
    push(32'h8, 32'hC, 32'hA000_0008);

    // Flush with ack in the same cycle
    step(1, 32'hBAD0_000C, 0, 1, 32'h100);
    chk("addr_C", imem.imem_addr, 32'hC);
    step(1, 32'hA000_0100, 0, 0, 0);
    chk("flush_addr", imem.imem_addr, 32'h100);
    chk("flush_bubble", {31'd0, id_valid}, 32'd0);
    push(32'h100, 32'h104, 32'hA000_0100);

    // Redirect to 0x10 (low bits ignored), then flush mid-request with 2 wait states
    step(1, 32'hBAD0_0104, 0, 1, 32'h13);
    step(0, 0, 0, 0, 0);
    chk("addr_10", imem.imem_addr, 32'h10);
    step(0, 0, 0, 1, 32'h200);
    step(0, 0, 0, 0, 0);
    chk("drain_addr", imem.imem_addr, 32'h10);
    chk("drain_req", {31'd0, imem.imem_req}, 32'd1);
    chk("drain_bubble", {31'd0, id_valid}, 32'd0);
    step(1, 32'hBAD0_0010, 0, 0, 0);
    step(1, 32'hA000_0200, 0, 0, 0);
    chk("drain_redirect", imem.imem_addr, 32'h200);
    push(32'h200, 32'h204, 32'hA000_0200);

    // Flush and stall together while in HOLD
    step(1, 32'hBAD0_0204, 1, 0, 0);
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("hf_req", {31'd0, imem.imem_req}, 32'd0);
    step(1, 32'hA000_FFFC, 0, 0, 0);
    chk("hf_valid", {31'd0, id_valid}, 32'd0);
    chk("hf_addr", imem.imem_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'h0, 32'hA000_FFFC);

    // Wrap, then reset while waiting
    step(1, 32'hB000_0000, 0, 0, 0);
    chk("wrap_addr", imem.imem_addr, 32'h0);
    chk("wrap_pc4", id_pc4, 32'h0);
    push(32'h0, 32'h4, 32'hB000_0000);
    step(0, 0, 0, 0, 0);
    chk("wait_addr", imem.imem_addr, 32'h4);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_mid_req", {31'd0, imem.imem_req}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("rst_mid_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_mid_addr", imem.imem_addr, 32'h0);
    chk("rst_mid_req1", {31'd0, imem.imem_req}, 32'd1);

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    done = 1'b1;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
